// File: rtl/display_scan_7seg.sv
// display_scan_7seg
//   Time-multiplexed driver for an N_DIGITS common-anode 7-segment display.
//   A prescaler divides clk into digit slots of PRESCALE cycles; each slot
//   lights one digit after a short anti-ghost guard interval.  New digit data
//   is captured into a pending register by a load strobe and is copied into
//   the display register only at a frame boundary, so a frame never mixes
//   old and new values.
//
// Ports
//   clk         : clock, all state updates on the rising edge
//   rst_n       : asynchronous active-low reset
//   en          : 1 runs the scan, 0 freezes it and blanks the display
//   load        : one-cycle strobe capturing digits/dp/blank into pending
//   digits      : hex nibble per digit, digit i = digits[4i+3:4i]
//   dp          : decimal-point request per digit (1 = lit)
//   blank       : forced blank per digit (1 = dark)
//   seg         : {g,f,e,d,c,b,a}, active-low
//   dp_n        : decimal point, active-low
//   an          : digit anodes, active-low, at most one low
//   scan_idx    : index of the current digit slot
//   frame_done  : one-cycle pulse at each frame boundary
module display_scan_7seg #(
  parameter int N_DIGITS = 4,
  parameter int PRESCALE = 50000,
  parameter int GUARD    = 2,
  parameter int LZS      = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        load,
  input  logic [4*N_DIGITS-1:0]       digits,
  input  logic [N_DIGITS-1:0]         dp,
  input  logic [N_DIGITS-1:0]         blank,
  output logic [6:0]                  seg,
  output logic                        dp_n,
  output logic [N_DIGITS-1:0]         an,
  output logic [$clog2(N_DIGITS)-1:0] scan_idx,
  output logic                        frame_done
);

  localparam int IW = $clog2(N_DIGITS);
  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

  // Scan state
  logic [PW-1:0]         pre_cnt_reg, pre_cnt_next;
  logic [IW-1:0]         scan_idx_reg, scan_idx_next;

  // Pending (written by load) and display (shown) registers
  logic [4*N_DIGITS-1:0] pend_nib_reg;
  logic [N_DIGITS-1:0]   pend_dp_reg, pend_blank_reg;
  logic                  pend_valid_reg;
  logic [4*N_DIGITS-1:0] disp_nib_reg, disp_nib_next;
  logic [N_DIGITS-1:0]   disp_dp_reg, disp_dp_next;
  logic [N_DIGITS-1:0]   disp_blank_reg, disp_blank_next;

  // Registered outputs
  logic [N_DIGITS-1:0]   an_reg, an_next;
  logic [6:0]            seg_reg, seg_next;
  logic                  dp_n_reg, dp_n_next;
  logic                  frame_done_reg;

  logic                  tick;
  logic                  last_slot;
  logic                  commit;
  logic                  guard_ok;
  logic                  lit;
  logic [3:0]            nib_sel;
  logic [3:0]            nib_next [N_DIGITS];
  logic [N_DIGITS-1:0]   zero_up;
  logic [N_DIGITS-1:0]   dark;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Prescaler, slot index and frame-boundary commit
  always_comb begin
    tick            = en && (pre_cnt_reg == PRE_LAST);
    last_slot       = (scan_idx_reg == IDX_LAST);
    commit          = tick && last_slot && pend_valid_reg;
    pre_cnt_next    = pre_cnt_reg;
    scan_idx_next   = scan_idx_reg;
    disp_nib_next   = disp_nib_reg;
    disp_dp_next    = disp_dp_reg;
    disp_blank_next = disp_blank_reg;
    if (en) begin
      pre_cnt_next = tick ? '0 : pre_cnt_reg + PW'(1);
    end
    if (tick) begin
      scan_idx_next = last_slot ? '0 : scan_idx_reg + IW'(1);
    end
    if (commit) begin
      disp_nib_next   = pend_nib_reg;
      disp_dp_next    = pend_dp_reg;
      disp_blank_next = pend_blank_reg;
    end
  end

  // Outputs are computed from the next state and registered, so the pins
  // reflect the state held in the registers with no input-to-output path.
  generate
    if (GUARD == 0) begin : g_no_guard
      assign guard_ok = 1'b1;
    end else begin : g_guard
      assign guard_ok = (pre_cnt_next >= PW'(GUARD));
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
      assign nib_next[gi] = disp_nib_next[4*gi +: 4];
      // All nibbles from this digit up to the most significant are zero
      assign zero_up[gi]  = (disp_nib_next[4*N_DIGITS-1:4*gi] == '0);
      if (LZS != 0 && gi > 0) begin : g_lzs
        assign dark[gi] = disp_blank_next[gi] | zero_up[gi];
      end else begin : g_plain
        assign dark[gi] = disp_blank_next[gi];
      end
      assign an_next[gi] = !(en && (scan_idx_next == IW'(gi)) && guard_ok && !dark[gi]);
    end
  endgenerate

  always_comb begin
    nib_sel   = nib_next[scan_idx_next];
    lit       = ~(&an_next);
    seg_next  = 7'h7F;
    dp_n_next = 1'b1;
    if (lit) begin
      seg_next  = hex7(nib_sel);
      dp_n_next = ~disp_dp_next[scan_idx_next];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_reg    <= '0;
      scan_idx_reg   <= '0;
      pend_nib_reg   <= '0;
      pend_dp_reg    <= '0;
      pend_blank_reg <= '1;
      pend_valid_reg <= 1'b0;
      disp_nib_reg   <= '0;
      disp_dp_reg    <= '0;
      disp_blank_reg <= '1;
      an_reg         <= '1;
      seg_reg        <= 7'h7F;
      dp_n_reg       <= 1'b1;
      frame_done_reg <= 1'b0;
    end else begin
      pre_cnt_reg    <= pre_cnt_next;
      scan_idx_reg   <= scan_idx_next;
      disp_nib_reg   <= disp_nib_next;
      disp_dp_reg    <= disp_dp_next;
      disp_blank_reg <= disp_blank_next;
      an_reg         <= an_next;
      seg_reg        <= seg_next;
      dp_n_reg       <= dp_n_next;
      frame_done_reg <= tick && last_slot;
      // A load coinciding with a commit wins: the commit already took the
      // old contents, and the new data stays pending for the next frame.
      if (load) begin
        pend_nib_reg   <= digits;
        pend_dp_reg    <= dp;
        pend_blank_reg <= blank;
        pend_valid_reg <= 1'b1;
      end else if (commit) begin
        pend_valid_reg <= 1'b0;
      end
    end
  end

  assign seg        = seg_reg;
  assign dp_n       = dp_n_reg;
  assign an         = an_reg;
  assign scan_idx   = scan_idx_reg;
  assign frame_done = frame_done_reg;

endmodule
